// File: rtl/core_pkg.sv
// Shared definitions for the pipelined RISC-V core: opcodes, the canonical NOP and the
// fetch FSM state type.
package core_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_STALL
  } fetch_state_e;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode of an arriving instruction word: B/J immediates and the static
// backward-taken/forward-not-taken decision.
module fetch_predecode
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o
);

  logic [6:0]      opcode;
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] b_imm;

  always_comb begin
    opcode = instr_i[6:0];
    j_imm  = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
              instr_i[30:21], 1'b0};
    b_imm  = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
              instr_i[11:8], 1'b0};
    // instr[31] is the sign of the B immediate: negative offset means backward branch
    taken_o  = (opcode == OP_JAL) || ((opcode == OP_BRANCH) && instr_i[31]);
    target_o = pc_i + ((opcode == OP_JAL) ? j_imm : b_imm);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, BRAM request port, one-entry skid and IF/ID register.
// Define FETCH_BTFN_EN to enable static backward-taken/forward-not-taken prediction.
module fetch_stage
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     IMEM_AW  = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               id_valid,
  output logic [XLEN-1:0]    id_pc,
  output logic [31:0]        id_instr,
  output logic               id_pred_taken,
  output logic               misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_v_q, req_v_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            skid_v_q, skid_v_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic            id_pred_q, id_pred_d;
  logic            misalign_q, misalign_d;

  logic            issue;
  logic [XLEN-1:0] issue_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

`ifdef FETCH_BTFN_EN
  fetch_predecode #(
    .XLEN(XLEN)
  ) u_predecode (
    .instr_i (imem_rdata),
    .pc_i    (req_pc_q),
    .taken_o (pred_taken),
    .target_o(pred_target)
  );
`else
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
`endif

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_v_d      = 1'b0;
    req_pc_d     = req_pc_q;
    skid_v_d     = skid_v_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    id_pred_d    = id_pred_q;
    misalign_d   = misalign_q | (redirect_valid & (|redirect_pc[1:0]));
    issue        = 1'b0;
    issue_pc     = fetch_pc_q;

    if (redirect_valid) begin
      // Dropping req_v for the old request is implicit: the new target replaces it.
      issue      = 1'b1;
      issue_pc   = {redirect_pc[XLEN-1:2], 2'b00};
      skid_v_d   = 1'b0;
      id_valid_d = 1'b0;
      id_pred_d  = 1'b0;
      state_d    = S_RUN;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          if (!stall) begin
            issue   = 1'b1;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (stall) begin
            if (req_v_q) begin
              skid_v_d     = 1'b1;
              skid_pc_d    = req_pc_q;
              skid_instr_d = imem_rdata;
              state_d      = S_STALL;
            end
          end else begin
            issue      = 1'b1;
            id_valid_d = req_v_q;
            id_pred_d  = req_v_q & pred_taken;
            if (req_v_q) begin
              id_pc_d    = req_pc_q;
              id_instr_d = imem_rdata;
              if (pred_taken) issue_pc = pred_target;
            end
          end
        end
        S_STALL: begin
          // Prediction is suppressed under stall, so a skid entry never carries one.
          if (!stall) begin
            issue      = 1'b1;
            id_valid_d = skid_v_q;
            id_pc_d    = skid_pc_q;
            id_instr_d = skid_instr_q;
            id_pred_d  = 1'b0;
            skid_v_d   = 1'b0;
            state_d    = S_RUN;
          end
        end
        default: state_d = S_BOOT;
      endcase
    end

    if (issue) begin
      req_v_d    = 1'b1;
      req_pc_d   = issue_pc;
      fetch_pc_d = issue_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_BOOT;
      fetch_pc_q   <= RESET_PC;
      req_v_q      <= 1'b0;
      req_pc_q     <= '0;
      skid_v_q     <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= NOP_INSTR;
      id_pred_q    <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_v_q      <= req_v_d;
      req_pc_q     <= req_pc_d;
      skid_v_q     <= skid_v_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
      id_pred_q    <= id_pred_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_en       = issue;
  assign imem_addr     = issue_pc[IMEM_AW+1:2];
  assign id_valid      = id_valid_q;
  assign id_pc         = id_pc_q;
  assign id_instr      = id_instr_q;
  assign id_pred_taken = id_pred_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stall/redirect traffic checked
// against an instruction-stream model (program order, hold under stall, flush on redirect).
module tb_fetch_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_pred_taken;
  logic        misalign;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];

  fetch_stage #(
    .XLEN    (64),
    .IMEM_AW (8),
    .RESET_PC(64'h0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_pred_taken (id_pred_taken),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM: data for the address presented this cycle is visible next cycle.
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] enc_beq(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  logic [63:0] tgt;
  logic [63:0] exp_pc;
  logic        p_stall, p_redir, p_valid;
  logic [63:0] p_pc;
  logic [31:0] p_instr;
  logic        mis_exp;
  logic        found;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i;
    // Words whose low 7 bits decode as JAL would loop on themselves under prediction
    mem[8'h6F] = NOP_INSTR;
    mem[8'hEF] = NOP_INSTR;
    reset_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_id_pc", id_pc, 64'd0);
    chk("rst_id_instr", 64'(id_instr), 64'(NOP_INSTR));
    chk("rst_id_pred", 64'(id_pred_taken), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);

    // 1: boot and sequential stream, instr = word address
    reset_n = 1'b1;
    #1;
    chk("boot_en", 64'(imem_en), 64'd1);
    chk("boot_addr", 64'(imem_addr), 64'd0);
    tick();
    chk("c1_valid", 64'(id_valid), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("seq_valid", 64'(id_valid), 64'd1);
      chk("seq_pc", id_pc, 64'(4 * k));
      chk("seq_instr", 64'(id_instr), 64'(k));
    end

    // 2: stall three cycles while id_pc = 0x10
    stall = 1'b1;
    #1;
    chk("stall_en", 64'(imem_en), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold_pc", id_pc, 64'h10);
      chk("stall_hold_valid", 64'(id_valid), 64'd1);
      if (k < 2) chk("stall_en_hold", 64'(imem_en), 64'd0);
    end
    stall = 1'b0;
    tick();
    chk("rel_pc0", id_pc, 64'h14);
    chk("rel_valid0", 64'(id_valid), 64'd1);
    tick();
    chk("rel_pc1", id_pc, 64'h18);
    chk("rel_instr1", 64'(id_instr), 64'h6);

    // 3: redirect to 0x40 while 0x1C is in flight
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    #1;
    chk("redir_en", 64'(imem_en), 64'd1);
    chk("redir_addr", 64'(imem_addr), 64'h10);
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush", 64'(id_valid), 64'd0);
    tick();
    chk("redir_pc0", id_pc, 64'h40);
    chk("redir_instr0", 64'(id_instr), 64'h10);
    chk("redir_valid0", 64'(id_valid), 64'd1);
    tick();
    chk("redir_pc1", id_pc, 64'h44);

    // 4: redirect together with stall while the skid is full
    stall = 1'b1;
    tick();
    chk("skid_hold_pc", id_pc, 64'h44);
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    #1;
    chk("rs_en", 64'(imem_en), 64'd1);
    tick();
    redirect_valid = 1'b0;
    chk("rs_flush0", 64'(id_valid), 64'd0);
    tick();
    chk("rs_flush1", 64'(id_valid), 64'd0);
    stall = 1'b0;
    tick();
    chk("rs_pc", id_pc, 64'h40);
    chk("rs_valid", 64'(id_valid), 64'd1);
    tick();
    chk("rs_pc1", id_pc, 64'h44);
    redirect_valid = 1'b1;
    redirect_pc = 64'h42;
    #1;
    chk("mis_addr", 64'(imem_addr), 64'h10);
    tick();
    redirect_valid = 1'b0;
    chk("mis_flag", 64'(misalign), 64'd1);
    chk("mis_flush", 64'(id_valid), 64'd0);
    tick();
    chk("mis_pc", id_pc, 64'h40);
    chk("mis_instr", 64'(id_instr), 64'h10);
    tick();
    chk("mis_sticky", 64'(misalign), 64'd1);

    // 5: reset mid-stall with the skid full
    stall = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(id_valid), 64'd0);
    chk("mrst_instr", 64'(id_instr), 64'(NOP_INSTR));
    chk("mrst_misalign", 64'(misalign), 64'd0);
    stall = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("mrst_boot_addr", 64'(imem_addr), 64'd0);
    chk("mrst_boot_en", 64'(imem_en), 64'd1);
    tick();
    tick();
    chk("mrst_pc0", id_pc, 64'h0);
    chk("mrst_valid0", 64'(id_valid), 64'd1);

`ifdef FETCH_BTFN_EN
    // 6: backward BEQ predicted taken, forward BEQ not
    mem[8]  = enc_beq(13'h1FF8);
    mem[12] = enc_beq(13'd16);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (id_valid && id_pc == 64'h20) found = 1'b1;
      else tick();
    end
    chk("btfn_found", 64'(found), 64'd1);
    chk("btfn_pred_bwd", 64'(id_pred_taken), 64'd1);
    tick();
    chk("btfn_tgt_pc", id_pc, 64'h18);
    chk("btfn_tgt_pred", 64'(id_pred_taken), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h30;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("btfn_fwd_pc", id_pc, 64'h30);
    chk("btfn_pred_fwd", 64'(id_pred_taken), 64'd0);
    tick();
    chk("btfn_fwd_next", id_pc, 64'h34);
    mem[8]  = 32'd8;
    mem[12] = 32'd12;
`endif

    // Random stall/redirect traffic against the stream model
    mis_exp = 1'b0;
    tgt = {$urandom, $urandom};
    tgt[1:0] = 2'b00;
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    exp_pc = tgt;
    p_redir = 1'b1;
    p_stall = 1'b0;
    p_valid = 1'b0;
    p_pc = 64'h0;
    p_instr = 32'h0;
    tick();
    for (int it = 0; it < 400; it++) begin
      if (p_redir) begin
        chk("rnd_flush", 64'(id_valid), 64'd0);
      end else if (p_stall) begin
        chk("rnd_hold_valid", 64'(id_valid), 64'(p_valid));
        chk("rnd_hold_pc", id_pc, p_pc);
        chk("rnd_hold_instr", 64'(id_instr), 64'(p_instr));
      end else begin
        chk("rnd_valid", 64'(id_valid), 64'd1);
        chk("rnd_pc", id_pc, exp_pc);
        chk("rnd_instr", 64'(id_instr), 64'(mem[exp_pc[9:2]]));
        chk("rnd_pred", 64'(id_pred_taken), 64'd0);
        exp_pc = exp_pc + 64'd4;
      end
      chk("rnd_misalign", 64'(misalign), 64'(mis_exp));
      p_valid = id_valid;
      p_pc = id_pc;
      p_instr = id_instr;
      p_stall = ($urandom_range(0, 3) == 0);
      p_redir = ($urandom_range(0, 9) == 0);
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      stall = p_stall;
      redirect_valid = p_redir;
      redirect_pc = tgt;
      if (p_redir) begin
        exp_pc = {tgt[63:2], 2'b00};
        if (tgt[1:0] != 2'b00) mis_exp = 1'b1;
      end
      #1;
      chk("rnd_en", 64'(imem_en), p_redir ? 64'd1 : 64'(!p_stall));
      if (p_redir) chk("rnd_addr", 64'(imem_addr), 64'(tgt[9:2]));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
